// File: rtl/mem_access_arbiter_pkg.sv
// mem_access_arbiter_pkg: arbiter types, MainMem port structs and big-endian lane helpers
package mem_access_arbiter_pkg;
  localparam int ADDR_LSB_WORD = 2;
  localparam int DATA_WIDTH = 32;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK, RMW_MERGE} st_mem_arb_e;
  typedef enum logic [1:0] {DS8, DS16, DS32} data_size_e;
  typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_e;
  typedef enum logic {ACC_READ, ACC_WRITE} access_type_e;
  typedef struct packed {
    logic req_mem_access;
    access_type_e access_type;
    logic [31:0] addr;
    word_t data;
  } port_in_main_mem_t;
  typedef struct packed {
    word_t data;
    logic wait_for_mem;
  } port_out_main_mem_t;
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & ~32'((1 << ADDR_LSB_WORD) - 1);
  endfunction
  // byte offset 0 is the most significant lane, so the shift counts down from the top
  function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] lo);
    return sz == DS8 ? {~lo, 3'b000} : sz == DS16 ? {~lo[1], 4'b0000} : 5'd0;
  endfunction
  function automatic word_t lane_mask(input logic [1:0] sz);
    return sz == DS8 ? word_t'(8'hff) : sz == DS16 ? word_t'(16'hffff) : '1;
  endfunction
  function automatic word_t lane_extract(input word_t w, input logic [1:0] sz, input logic [1:0] lo);
    return (w >> lane_shift(sz, lo)) & lane_mask(sz);
  endfunction
  function automatic word_t lane_merge(input word_t old, input word_t wd, input logic [1:0] sz, input logic [1:0] lo);
    return (old & ~(lane_mask(sz) << lane_shift(sz, lo))) | ((wd & lane_mask(sz)) << lane_shift(sz, lo));
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return sz == DS8 ? 1'b0 : sz == DS16 ? lo[0] : |lo;
  endfunction
endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: CPU fetch and load/store handshakes plus the MainMem port pair
interface mem_access_arbiter_if;
  import mem_access_arbiter_pkg::*;
  logic ifetch_req;
  logic [31:0] ifetch_addr;
  logic ifetch_ack;
  word_t ifetch_data;
  logic dmem_req;
  logic dmem_we;
  logic [1:0] dmem_size;
  logic [31:0] dmem_addr;
  word_t dmem_wdata;
  logic dmem_ack;
  word_t dmem_rdata;
  logic dmem_err;
  port_in_main_mem_t mem_out;
  port_out_main_mem_t mem_in;
  modport slave(
    input ifetch_req, ifetch_addr, dmem_req, dmem_we, dmem_size, dmem_addr, dmem_wdata, mem_in,
    output ifetch_ack, ifetch_data, dmem_ack, dmem_rdata, dmem_err, mem_out
  );
  modport master(
    output ifetch_req, ifetch_addr, dmem_req, dmem_we, dmem_size, dmem_addr, dmem_wdata, mem_in,
    input ifetch_ack, ifetch_data, dmem_ack, dmem_rdata, dmem_err, mem_out
  );
endinterface

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: merges store lanes into an old word and extracts the addressed load lane
module mem_lane_merge
  import mem_access_arbiter_pkg::*;
(
  input  word_t      old_word,
  input  word_t      wdata,
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output word_t      merged,
  output word_t      rdata
);
  assign merged = lane_merge(old_word, wdata, size, addr_lo);
  assign rdata = lane_extract(old_word, size, addr_lo);
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: fetch/load-store arbiter onto MainMem with sub-word RMW; MEM_ARB_MISALIGN_TRAP_EN traps misaligned data accesses
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mem_access_arbiter_if.slave bus
);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  st_mem_arb_e state, state_nx;
  grant_e gnt, gnt_nx, last, last_nx;
  logic err, err_nx, dm_sub, unused_wait;
  word_t if_data_q, dm_data_q, merged, rd_lane;
  assign dm_sub = bus.dmem_size == DS8 || bus.dmem_size == DS16;
  assign unused_wait = bus.mem_in.wait_for_mem;
  mem_lane_merge u_lane (
    .old_word(bus.mem_in.data),
    .wdata(bus.dmem_wdata),
    .size(bus.dmem_size),
    .addr_lo(bus.dmem_addr[1:0]),
    .merged(merged),
    .rdata(rd_lane)
  );
  // IDLE drives MainMem straight from the winning port; rst_n gates it so reset silences the bus at once
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    last_nx = last;
    err_nx = err;
    bus.mem_out = '0;
    bus.ifetch_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_err = 1'b0;
    bus.ifetch_data = if_data_q;
    bus.dmem_rdata = dm_data_q;
    case (state)
      IDLE: if (rst_n && (bus.ifetch_req || bus.dmem_req)) begin
        gnt_nx = bus.dmem_req && !(bus.ifetch_req && last == GRANT_DATA) ? GRANT_DATA : GRANT_FETCH;
        last_nx = gnt_nx;
        err_nx = gnt_nx == GRANT_DATA && TRAP_EN && misaligned(bus.dmem_size, bus.dmem_addr[1:0]);
        bus.mem_out.req_mem_access = !err_nx;
        bus.mem_out.addr = word_addr(gnt_nx == GRANT_DATA ? bus.dmem_addr : bus.ifetch_addr);
        bus.mem_out.access_type = gnt_nx == GRANT_DATA && bus.dmem_we && !dm_sub ? ACC_WRITE : ACC_READ;
        bus.mem_out.data = bus.dmem_wdata;
        state_nx = err_nx ? WR_ACK : gnt_nx == GRANT_FETCH || !bus.dmem_we ? RD_WAIT : dm_sub ? RMW_MERGE : WR_ACK;
      end
      RD_WAIT: begin
        bus.ifetch_ack = gnt == GRANT_FETCH;
        bus.dmem_ack = gnt == GRANT_DATA;
        bus.ifetch_data = gnt == GRANT_FETCH ? bus.mem_in.data : if_data_q;
        bus.dmem_rdata = gnt == GRANT_DATA ? rd_lane : dm_data_q;
        state_nx = IDLE;
      end
      RMW_MERGE: begin
        bus.mem_out.req_mem_access = 1'b1;
        bus.mem_out.access_type = ACC_WRITE;
        bus.mem_out.addr = word_addr(bus.dmem_addr);
        bus.mem_out.data = merged;
        state_nx = WR_ACK;
      end
      WR_ACK: begin
        bus.dmem_ack = 1'b1;
        bus.dmem_err = err;
        bus.dmem_rdata = err ? '0 : dm_data_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= GRANT_FETCH;
      last <= GRANT_FETCH;
      err <= 1'b0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      last <= last_nx;
      err <= err_nx;
      if_data_q <= bus.ifetch_data;
      dm_data_q <= bus.dmem_rdata;
    end
  end
endmodule
